alu_writeback_stage: RTL
========================

Name: alu_writeback_stage

Overview:
- Sits directly downstream of the ALU and captures its 64-bit result into the Z register pair (z_hi, z_lo), together with the zero flag, op code and destination register.
- Sequences the write-back onto the shared write port:
  - one write to general register Rd for 32-bit ops;
  - a LO write then a HI write for MUL/DIV.
- Uses a valid/ready handshake upstream and a request/grant handshake toward the register file.
- Provides a grant-timeout abort.

Parameters:
- RD_W, 4, destination register index width (16 GPRs).
- WB_TIMEOUT, 16, max cycles to wait for wb_gnt in any write state; 0 disables the timeout.
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > WB_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  ALU result, op and rd are valid this cycle.
- in_ready  out  1  stage can accept a result.
- alu_result  in  64  ALU result; MUL = product, DIV = {remainder, quotient}.
- alu_zero  in  1  ALU zero flag.
- alu_op  in  4  ALU op code that produced alu_result.
- rd_sel  in  RD_W  destination GPR index.
- wb_gnt  in  1  register-file write port grants the current request.
- wb_req  out  1  write request pending.
- wb_data  out  32  write data.
- wb_rd  out  RD_W  GPR index, valid when wb_gpr_en.
- wb_gpr_en  out  1  request targets GPR[wb_rd].
- wb_lo_en  out  1  request targets LO.
- wb_hi_en  out  1  request targets HI.
- z_hi  out  32  captured upper result.
- z_lo  out  32  captured lower result.
- zero_flag  out  1  captured zero flag.
- done  out  1  one-cycle pulse: sequence finished or aborted.
- err  out  1  one-cycle pulse with done: illegal op or timeout.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset:** rst_n sampled low at a clk edge forces the following, regardless of state:
  - state = IDLE;
  - z_hi, z_lo, zero_flag, wb_data, wb_rd, the latched op, the latched rd and the timeout counter = 0;
  - wb_req, wb_gpr_en, wb_lo_en, wb_hi_en, done, err, busy = 0;
  - in_ready = 1 from the first cycle after reset.
  - An in-flight sequence is dropped; no further write strobes are issued.
- **FSM states:** IDLE, WB_GPR, WB_LO, WB_HI.
- **IDLE:**
  - in_ready = 1.
  - On in_valid: latch z_hi/z_lo <= alu_result, zero_flag <= alu_zero, op and rd.
  - Next state by alu_op:
    - op 4'b0101 (MUL) or 4'b0110 (DIV) -> WB_LO;
    - op 4'b0000..4'b0100 or 4'b0111..4'b1100 -> WB_GPR;
    - op 4'b1101..4'b1111 -> stay IDLE, with done = 1 and err = 1 next cycle and no write strobes.
  - z_hi/z_lo still capture in the illegal-op case.
- **in_ready** is 0 in all non-IDLE states; in_valid is ignored there.
- **WB_GPR:** wb_req = 1, wb_gpr_en = 1, wb_rd = latched rd, wb_data = z_lo.
  - On wb_gnt -> IDLE, with done = 1 in the next cycle.
- **WB_LO:** wb_req = 1, wb_lo_en = 1, wb_data = z_lo.
  - On wb_gnt -> WB_HI.
- **WB_HI:** wb_req = 1, wb_hi_en = 1, wb_data = z_hi.
  - On wb_gnt -> IDLE, with done = 1 in the next cycle.
- **Request outputs:**
  - They are registered and change only on state transitions.
  - At most one of wb_gpr_en, wb_lo_en, wb_hi_en is high at a time.
  - They are all 0 in IDLE.
- **Handshake:**
  - A write completes in the cycle where wb_req & wb_gnt = 1.
  - wb_gnt while wb_req = 0 is ignored.
  - Outputs hold stable while waiting for a grant.
- **Latency with wb_gnt tied high:**
  - Accept at cycle 0 -> wb_req high at cycle 1.
  - GPR op: done at cycle 2.
  - MUL/DIV: LO at cycle 1, HI at cycle 2, done at cycle 3.
- **Back-to-back:**
  - In the done cycle the state is IDLE, so in_ready = 1 and a new result may be accepted that same cycle.
  - z_hi/z_lo keep the previous value until the next accept.
- **Timeout (WB_TIMEOUT > 0):**
  - The counter clears on entry to each WB_* state and increments each cycle wb_req = 1 without wb_gnt.
  - When the count reaches WB_TIMEOUT with no grant -> IDLE, with done = 1 and err = 1 the next cycle.
  - For MUL/DIV, a LO write already completed is not undone; HI is not written.
- **Simultaneous events:**
  - A grant on the same edge the counter reaches WB_TIMEOUT counts as a grant; no error.
  - rst_n low has priority over everything.
- **Other:** done and err are never high for more than one cycle. busy = (state != IDLE).

Test Plan:
- ADD: op = 0011, result = 64'h0000_0000_0000_0025, rd = 5, wb_gnt = 1 -> cycle 1: wb_gpr_en = 1, wb_rd = 5, wb_data = 32'h25; cycle 2: done = 1, err = 0, zero_flag = 0.
- MUL: op = 0101, result = 64'h0000_0001_FFFF_FFFE, wb_gnt = 1 -> LO write of 32'hFFFF_FFFE at cycle 1, HI write of 32'h1 at cycle 2, done at cycle 3; in_valid held high during busy is not accepted.
- Grant stall: DIV with wb_gnt low for 3 cycles then high for 2 cycles -> wb_lo_en held 4 cycles with wb_data stable, then wb_hi_en for 1 cycle, then done; no err.
- Timeout: WB_TIMEOUT = 4, SUB op, wb_gnt = 0 -> wb_req for 4 cycles, then IDLE with done = 1 and err = 1 together and no write; next accept works.
- Illegal op 4'b1110 and reset mid-op -> illegal op: no wb_req, done = err = 1 at cycle 1. Separately, rst_n low during WB_HI -> all outputs 0, in_ready = 1 the next cycle, no HI write.
- Zero and back-to-back: SUB result = 0 with alu_zero = 1 -> zero_flag = 1. A second AND issued in the done cycle is accepted, with its wb_req one cycle later.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// ALU write-back stage: captures the 64-bit ALU result into the Z register
// pair and sequences it onto the shared register-file write port. Narrow ops
// need one GPR write. MUL/DIV need a LO write followed by a HI write.
// A grant timeout aborts a stalled sequence.
module alu_writeback_stage #(
  parameter int RD_W       = 4,
  parameter int WB_TIMEOUT = 16,
  parameter int TO_W       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     alu_result,
  input  logic            alu_zero,
  input  logic [3:0]      alu_op,
  input  logic [RD_W-1:0] rd_sel,
  input  logic            wb_gnt,
  output logic            wb_req,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_gpr_en,
  output logic            wb_lo_en,
  output logic            wb_hi_en,
  output logic [31:0]     z_hi,
  output logic [31:0]     z_lo,
  output logic            zero_flag,
  output logic            done,
  output logic            err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_GPR = 2'd1,
    WB_LO  = 2'd2,
    WB_HI  = 2'd3
  } state_t;

  // The counter value seen in the last allowed waiting cycle; a missing
  // grant there ends the sequence with an error.
  localparam logic [TO_W-1:0] TO_LAST = (WB_TIMEOUT > 0) ? TO_W'(WB_TIMEOUT - 1) : '0;
  localparam bit              TO_ON   = (WB_TIMEOUT > 0);

  state_t            r_state;
  logic [31:0]       r_zHi;
  logic [31:0]       r_zLo;
  logic              r_zero;
  logic [3:0]        r_op;
  logic [RD_W-1:0]   r_rd;
  logic [TO_W-1:0]   r_cnt;
  logic              r_req;
  logic [31:0]       r_data;
  logic [RD_W-1:0]   r_wbRd;
  logic              r_gprEn;
  logic              r_loEn;
  logic              r_hiEn;
  logic              r_done;
  logic              r_err;

  logic              w_timeout;
  logic              w_wideOp;

  // MUL and DIV produce a 64-bit result that needs both LO and HI writes.
  function automatic logic isWide(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b0110);
  endfunction

  // Op codes 1101..1111 are not produced by any legal ALU operation.
  function automatic logic isIllegal(input logic [3:0] op);
    return op >= 4'b1101;
  endfunction

  assign w_timeout = TO_ON && (r_cnt == TO_LAST);
  assign w_wideOp  = isWide(r_op);

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign wb_req    = r_req;
  assign wb_data   = r_data;
  assign wb_rd     = r_wbRd;
  assign wb_gpr_en = r_gprEn;
  assign wb_lo_en  = r_loEn;
  assign wb_hi_en  = r_hiEn;
  assign z_hi      = r_zHi;
  assign z_lo      = r_zLo;
  assign zero_flag = r_zero;
  assign done      = r_done;
  assign err       = r_err;

  // Single state machine: capture, request strobes, grant wait and abort, all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_zHi   <= '0;
      r_zLo   <= '0;
      r_zero  <= 1'b0;
      r_op    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_wbRd  <= '0;
      r_gprEn <= 1'b0;
      r_loEn  <= 1'b0;
      r_hiEn  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_zHi  <= alu_result[63:32];
            r_zLo  <= alu_result[31:0];
            r_zero <= alu_zero;
            r_op   <= alu_op;
            r_rd   <= rd_sel;
            r_cnt  <= '0;
            if (isWide(alu_op)) begin
              r_state <= WB_LO;
              r_req   <= 1'b1;
              r_loEn  <= 1'b1;
              r_data  <= alu_result[31:0];
            end else if (isIllegal(alu_op)) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state <= WB_GPR;
              r_req   <= 1'b1;
              r_gprEn <= 1'b1;
              r_wbRd  <= rd_sel;
              r_data  <= alu_result[31:0];
            end
          end
        end

        WB_GPR, WB_HI: begin
          if (wb_gnt) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_gprEn <= 1'b0;
            r_loEn  <= 1'b0;
            r_hiEn  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_gprEn <= 1'b0;
            r_loEn  <= 1'b0;
            r_hiEn  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WB_LO: begin
          if (wb_gnt) begin
            if (w_wideOp) begin
              r_state <= WB_HI;
              r_loEn  <= 1'b0;
              r_hiEn  <= 1'b1;
              r_data  <= r_zHi;
              r_cnt   <= '0;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
              r_loEn  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_gprEn <= 1'b0;
            r_loEn  <= 1'b0;
            r_hiEn  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_gprEn <= 1'b0;
          r_loEn  <= 1'b0;
          r_hiEn  <= 1'b0;
        end
      endcase
    end
  end

endmodule
